// File: rtl/inst_sram_responder.sv
// Slave end of the SRAM-like instruction fetch interface: accepts requests into a
// single-port synchronous RAM and returns responses strictly in order via a small FIFO.
module inst_sram_responder #(
    parameter int DEPTH_LOG2 = 2,
    parameter int MEM_AW     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_en,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic [3:0]            req_wstrb,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [31:0]           rdata,
    input  logic                  stall_addr,
    input  logic                  stall_data,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [MEM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [DEPTH_LOG2:0]   outstanding
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic                  pend_valid_q, pend_valid_d;
    logic                  pend_wr_q, pend_wr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   fifo_count_q, fifo_count_d;
    logic [DEPTH_LOG2:0]   outstanding_q, outstanding_d;
    logic [31:0]           fifo_mem [DEPTH];

    logic                  accept;
    logic                  fifo_nonempty;
    logic                  push;
    logic                  pop;
    logic [31:0]           pend_data;

    // Size and the address bits outside the RAM window never affect the access.
    logic unused_req_bits;
    assign unused_req_bits = ^{req_size, req_addr[31:MEM_AW+2], req_addr[1:0]};

    // NOTE: every output of an always_comb gets a default before any branch, so no latch is inferred.
    always_comb begin
        addr_ok       = 1'b0;
        accept        = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 4'b0;
        ram_addr      = req_addr[MEM_AW+1:2];
        ram_wdata     = req_wdata;
        data_ok       = 1'b0;
        rdata         = 32'h0;
        push          = 1'b0;
        pop           = 1'b0;

        // Full is judged on the registered count only: no pop-through to addr_ok.
        addr_ok       = ~reset & ~stall_addr & (outstanding_q < DEPTH_CNT);
        accept        = req_en & addr_ok;
        ram_en        = accept;
        ram_we        = (accept && req_wr) ? req_wstrb : 4'b0;

        fifo_nonempty = (fifo_count_q != '0);
        pend_data     = pend_wr_q ? 32'h0 : ram_rdata;
        data_ok       = (fifo_nonempty | pend_valid_q) & ~stall_data & ~reset;
        if (data_ok) begin
            rdata = fifo_nonempty ? fifo_mem[rd_ptr_q] : pend_data;
        end

        // The pending word bypasses the FIFO only when nothing older is queued.
        pop  = fifo_nonempty & data_ok;
        push = pend_valid_q & (fifo_nonempty | ~data_ok);

        pend_valid_d  = accept;
        pend_wr_d     = accept & req_wr;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fifo_count_d  = fifo_count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
        outstanding_d = outstanding_q + {{DEPTH_LOG2{1'b0}}, accept}
                                      - {{DEPTH_LOG2{1'b0}}, data_ok};
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q  <= 1'b0;
            pend_wr_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_wr_q     <= pend_wr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
        end
    end

    // NOTE: FIFO storage is not reset; the cleared count and pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pend_data;
        end
    end

    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: a behavioural RAM plus an in-order
// response queue predict every handshake, RAM-port and response value each cycle.
module tb_inst_sram_responder;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
    localparam int MEM_AW     = 14;
    localparam int MEM_WORDS  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_en, req_wr;
    logic [1:0]        req_size;
    logic [3:0]        req_wstrb;
    logic [31:0]       req_addr, req_wdata;
    logic              addr_ok, data_ok;
    logic [31:0]       rdata;
    logic              stall_addr, stall_data;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;
    logic [DEPTH_LOG2:0] outstanding;

    inst_sram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset), .req_en(req_en), .req_wr(req_wr), .req_size(req_size),
        .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .stall_addr(stall_addr), .stall_data(stall_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    // Physical RAM driven by the DUT's port, and the bench's own view of memory contents.
    logic [31:0] ram     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram[ram_addr];
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    logic        last_accept;
    logic        last_data_ok;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already set; predict and compare, then advance.
    task automatic cycle();
        logic        exp_aok, exp_dok, acc;
        logic [31:0] exp_rd;
        int          idx;
        #1;
        exp_aok = !reset && !stall_addr && (exp_q.size() < DEPTH);
        exp_dok = !reset && !stall_data && (exp_q.size() > 0);
        exp_rd  = exp_dok ? exp_q[0] : 32'h0;
        check("outstanding", 32'(outstanding), exp_q.size());
        check("addr_ok", 32'(addr_ok), 32'(exp_aok));
        check("data_ok", 32'(data_ok), 32'(exp_dok));
        check("rdata", rdata, exp_rd);
        if (exp_dok) void'(exp_q.pop_front());
        acc = req_en && exp_aok;
        check("ram_en", 32'(ram_en), 32'(acc));
        check("ram_we", 32'(ram_we), (acc && req_wr) ? 32'(req_wstrb) : 32'h0);
        if (acc) begin
            idx = int'(req_addr[MEM_AW+1:2]);
            check("ram_addr", 32'(ram_addr), 32'(idx));
            check("ram_wdata", ram_wdata, req_wdata);
            if (req_wr) begin
                exp_q.push_back(32'h0);
                for (int b = 0; b < 4; b++)
                    if (req_wstrb[b]) ref_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
                exp_q.push_back(ref_mem[idx]);
            end
        end
        if (reset) exp_q.delete();
        last_accept  = acc;
        last_data_ok = data_ok;
        last_rdata   = rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic en, input logic wr, input logic [31:0] addr,
                           input logic [3:0] strb, input logic [31:0] wdata);
        req_en    = en;
        req_wr    = wr;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wdata;
        req_size  = 2'($urandom_range(0, 2));
    endtask

    initial begin
        int accepts;
        int cyc;
        logic [31:0] v;
        for (int i = 0; i < MEM_WORDS; i++) begin
            v = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[14'h100]     = 32'h2402_0001;
        ref_mem[14'h100] = 32'h2402_0001;
        ram[14'h200]     = 32'h1234_5678;
        ref_mem[14'h200] = 32'h1234_5678;

        reset = 1'b1; stall_addr = 1'b0; stall_data = 1'b0;
        set_req(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle();

        // Single read at a high physical address that wraps onto word 0x100.
        set_req(1'b1, 1'b0, 32'hBFC0_0400, 4'h0, 32'h0);
        cycle();
        check("single_accept", 32'(last_accept), 32'h1);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("single_data_ok", 32'(last_data_ok), 32'h1);
        check("single_rdata", last_rdata, 32'h2402_0001);
        cycle();

        // Streaming: 8 back-to-back reads, one response per cycle.
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0);
            cycle();
            if (i > 0) check("stream_data_ok", 32'(last_data_ok), 32'h1);
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("stream_last", last_rdata, ref_mem[7]);
        cycle();

        // Full: stall responses, hold req_en, expect exactly DEPTH accepts.
        stall_data = 1'b1;
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, 1'b0, 32'(32'h40 + i * 4), 4'h0, 32'h0);
            cycle();
            if (last_accept) accepts++;
        end
        check("full_accepts", 32'(accepts), DEPTH);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stall_data = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Write partial bytes, then read the merged word back.
        set_req(1'b1, 1'b1, 32'h0000_0800, 4'b0011, 32'hAAAA_5555);
        cycle();
        set_req(1'b1, 1'b0, 32'h0000_0800, 4'h0, 32'h0);
        cycle();
        check("wr_resp", last_rdata, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("rd_after_wr", last_rdata, 32'h1234_5555);
        cycle();

        // Random throttling until 1000 accepts, bounded in cycles.
        accepts = 0;
        cyc = 0;
        while (accepts < 1000 && cyc < 8000) begin
            stall_addr = ($urandom_range(0, 9) < 3);
            stall_data = ($urandom_range(0, 9) < 3);
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    $urandom, 4'($urandom), $urandom);
            cycle();
            if (last_accept) accepts++;
            cyc++;
        end
        check("rand_accepts", 32'(accepts), 32'd1000);
        stall_addr = 1'b0;
        stall_data = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 20) begin
            cycle();
            cyc++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'h0);
        cycle();

        // Reset with three responses outstanding: all are dropped.
        stall_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 1'b0, 32'(32'h100 + i * 4), 4'h0, 32'h0);
            cycle();
        end
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        stall_data = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("post_reset_outstanding", 32'(outstanding), 32'h0);
        cycle();
        cycle();
        set_req(1'b1, 1'b0, 32'hBFC0_0400, 4'h0, 32'h0);
        cycle();
        set_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cycle();
        check("post_reset_rdata", last_rdata, 32'h2402_0001);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_sram_responder.md
# inst_sram_responder

Slave end of the SRAM-like fetch interface: accepts `req_en`/`addr_ok` requests from the fetch stage and returns `data_ok`/`rdata` strictly in order. Requests are served from a synchronous single-port RAM with 1-cycle read latency. An internal response FIFO lets up to `DEPTH` requests be outstanding. Two throttle inputs let benches exercise every fetch-stage handshake corner without a cache or AXI bridge.

## Interface
- `DEPTH_LOG2`, 2: log2 of the maximum outstanding requests. `DEPTH = 2**DEPTH_LOG2`, and `DEPTH >= 2`.
- `MEM_AW`, 14: RAM word-address width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_en` in 1: request valid.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_size` in 2: transfer size. It does not change the returned word.
- `req_wstrb` in 4: byte write enables, used only when `req_wr=1`.
- `req_addr` in 32: physical byte address.
- `req_wdata` in 32: write data.
- `addr_ok` out 1: request accepted this cycle when `req_en` is also high.
- `data_ok` out 1: one response delivered this cycle. There is no ready signal; the initiator must take it.
- `rdata` out 32: response data, valid only with `data_ok`.
- `stall_addr` in 1: forces `addr_ok=0`.
- `stall_data` in 1: forces `data_ok=0`.
- `ram_en` out 1: RAM port enable.
- `ram_we` out 4: RAM byte write enables.
- `ram_addr` out MEM_AW: RAM word address.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid the cycle after `ram_en` with `ram_we=0`.
- `outstanding` out DEPTH_LOG2+1: accepted requests not yet answered.

## Operation
- **Accept condition.** `accept = req_en & addr_ok`.
  - `addr_ok = ~reset & ~stall_addr & (outstanding < DEPTH)`.
  - `addr_ok` must not depend on same-cycle `data_ok`, so there is no combinational pop-through.
  - `addr_ok` may be high while `req_en` is low.
- **RAM access on accept.** In the accept cycle:
  - `ram_en=1` and `ram_addr=req_addr[MEM_AW+1:2]`. Upper address bits are ignored, so the address space wraps.
  - `ram_we = req_wr ? req_wstrb : 4'b0`.
  - `ram_wdata=req_wdata`.
  - When there is no accept, `ram_en=0` and `ram_we=0`.
- **Unaligned and sub-word requests.** `req_addr[1:0]` and `req_size` do not alter access for reads: the full aligned word is returned. Unaligned-fetch exceptions are raised by the initiator.
- **Pending stage.** A 1-entry stage captures each accept: `pend_valid` and `pend_wr` are registered.
  - The response data is `ram_rdata` for a read and 32'h0 for a write.
  - In the cycle after the accept, this data either goes out as the response (bypass) or is pushed into the FIFO.
- **Response FIFO.** `DEPTH` entries of 32 bits, circular, with wrapping read and write pointers.
  - The head is the oldest entry.
  - Push and pop may occur in the same cycle.
- **Response select.**
  - `resp_avail = fifo_nonempty | pend_valid`.
  - `data_ok = resp_avail & ~stall_data & ~reset`.
  - `rdata` is the FIFO head if the FIFO is non-empty, else the pending data. `rdata` is 0 whenever `data_ok=0`.
- **Pending-stage disposition.** When `pend_valid`:
  - If the FIFO is empty and `data_ok=1`: consumed directly, no push.
  - Otherwise: pushed into the FIFO.
  - When the FIFO is non-empty and `data_ok=1`: pop the head.
- **Outstanding count.** `outstanding <= outstanding + accept - data_ok`.
  - Invariant: `outstanding = pend_valid + fifo_count <= DEPTH`. The FIFO never overflows.
- **No cancel.** Every accepted request gets exactly one `data_ok`, in acceptance order. Discarding stale data after a flush is the initiator's job.
- **Reset.** Clears pointers, `pend_valid` and `outstanding`. In-flight responses are dropped and never delivered.

## Timing
- **Reset values.** During reset and in the cycle after reset deasserts, before any accept:
  - `addr_ok=0` during reset.
  - `data_ok=0`.
  - `rdata=0`.
  - `ram_en=0`.
  - `ram_we=0`.
  - `outstanding=0`.
- **Latency.** Accept in cycle N → earliest `data_ok` in cycle N+1 (bypass path). Each cycle of `stall_data` or older queued responses adds one cycle.
- **Throughput.** Back-to-back accepts every cycle sustain one `data_ok` per cycle.
- **Full.** `outstanding=DEPTH` → `addr_ok=0`. It re-asserts in the cycle after the first `data_ok`.
- **Read after write, same word.** Write accepted at N, read accepted at N+1 or later → the read returns the updated bytes.
- **Reset mid-operation.** Reset at cycle R with requests outstanding → `data_ok=0` from R onward, until new accepts occur after reset deasserts.

## Test plan
- **Single read.** RAM word `0x100 = 32'h2402_0001`; read accepted at addr `0xBFC0_0400` (MEM_AW=14 → word `0x100`) in cycle N → `data_ok=1` and `rdata=32'h2402_0001` in N+1, `outstanding` returns to 0.
- **Streaming.** 8 back-to-back reads of words 0..7 with `stall_data=0` → `data_ok` on 8 consecutive cycles starting one cycle after the first accept, data in order.
- **Full/backpressure.** `stall_data=1`, DEPTH=4, `req_en` held high → exactly 4 accepts, then `addr_ok=0`. Release `stall_data` → 4 in-order responses, and `addr_ok` re-asserts the cycle after the first `data_ok`.
- **Write then read.** Write `wstrb=4'b0011`, `wdata=32'hAAAA_5555` to a word holding `32'h1234_5678` → write `data_ok` with `rdata=0`, then a read returns `32'h1234_5555`.
- **Throttling.** Random `stall_addr`/`stall_data` over 1000 reads → every accept is matched by exactly one in-order `data_ok`, and `outstanding` never exceeds DEPTH.
- **Reset mid-operation.** Assert reset with 3 responses outstanding → no `data_ok` afterwards, `outstanding=0`, and the first new read responds normally.
